// File: rtl/csr_trap_controller.sv
`default_nettype none
// ============================================================================
// Module  : csr_trap_controller
// Brief   : Arbitrates trap-entry, mret and RS CSR writes onto one CSR write
//           port; issues flush/redirect. Define CSR_TRAP_COUNT_EN for trap_count.
// Revision: 1.0
// ============================================================================
module csr_trap_controller #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
    parameter logic [11:0] CAUSE_ADDR  = 12'h001,
    parameter logic [11:0] EPC_ADDR    = 12'h002,
    parameter int          CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exc_valid,
    input  logic [31:0]      exc_pc,
    input  logic [4:0]       exc_cause,
    output logic             exc_ack,
    input  logic             mret_valid,
    output logic             mret_ack,
    input  logic             csr_wr_valid,
    input  logic [11:0]      csr_wr_addr,
    input  logic [31:0]      csr_wr_data,
    output logic             csr_wr_ready,
    input  logic [31:0]      epc_in,
    output logic             csr_we,
    output logic [11:0]      csr_waddr,
    output logic [31:0]      csr_wdata,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             busy,
    output logic [CNT_W-1:0] trap_count
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SAVE_EPC   = 3'd1,
        SAVE_CAUSE = 3'd2,
        REDIRECT   = 3'd3,
        MRET       = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        buf_full_q, buf_full_d;
    logic [11:0] buf_addr_q, buf_addr_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic [4:0]  exc_cause_q, exc_cause_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_full_q  <= 1'b0;
            buf_addr_q  <= 12'h000;
            buf_data_q  <= 32'h0;
            exc_pc_q    <= 32'h0;
            exc_cause_q <= 5'h0;
        end else begin
            state_q     <= state_d;
            buf_full_q  <= buf_full_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            exc_pc_q    <= exc_pc_d;
            exc_cause_q <= exc_cause_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        buf_full_d     = buf_full_q;
        buf_addr_d     = buf_addr_q;
        buf_data_d     = buf_data_q;
        exc_pc_d       = exc_pc_q;
        exc_cause_d    = exc_cause_q;
        exc_ack        = 1'b0;
        mret_ack       = 1'b0;
        csr_wr_ready   = 1'b0;
        csr_we         = 1'b0;
        csr_waddr      = 12'h000;
        csr_wdata      = 32'h0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        case (state_q)
            IDLE: begin
                csr_wr_ready = !buf_full_q && !exc_valid;
                if (exc_valid) begin
                    // The pending buffered write is squashed by the coming flush.
                    exc_ack     = 1'b1;
                    exc_pc_d    = exc_pc;
                    exc_cause_d = exc_cause;
                    buf_full_d  = 1'b0;
                    state_d     = SAVE_EPC;
                end else if (buf_full_q) begin
                    csr_we     = 1'b1;
                    csr_waddr  = buf_addr_q;
                    csr_wdata  = buf_data_q;
                    buf_full_d = 1'b0;
                end else begin
                    if (mret_valid) begin
                        mret_ack = 1'b1;
                        state_d  = MRET;
                    end
                    if (csr_wr_valid) begin
                        buf_full_d = 1'b1;
                        buf_addr_d = csr_wr_addr;
                        buf_data_d = csr_wr_data;
                    end
                end
            end
            SAVE_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = EPC_ADDR;
                csr_wdata = exc_pc_q;
                state_d   = SAVE_CAUSE;
            end
            SAVE_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = CAUSE_ADDR;
                csr_wdata = {27'b0, exc_cause_q};
                state_d   = REDIRECT;
            end
            REDIRECT: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = TRAP_VECTOR;
                state_d        = IDLE;
            end
            MRET: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = epc_in;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are quiet for as long as reset is held, not just after it.
        if (reset) begin
            exc_ack        = 1'b0;
            mret_ack       = 1'b0;
            csr_wr_ready   = 1'b0;
            csr_we         = 1'b0;
            csr_waddr      = 12'h000;
            csr_wdata      = 32'h0;
            flush          = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = 32'h0;
        end
    end

    assign busy = !reset && ((state_q != IDLE) || buf_full_q);

`ifdef CSR_TRAP_COUNT_EN
    logic [CNT_W-1:0] trap_cnt_q, trap_cnt_d;

    always_comb begin
        trap_cnt_d = trap_cnt_q;
        if (state_q == REDIRECT && trap_cnt_q != {CNT_W{1'b1}}) begin
            trap_cnt_d = trap_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap_cnt_q <= '0;
        end else begin
            trap_cnt_q <= trap_cnt_d;
        end
    end

    assign trap_count = trap_cnt_q;
`else
    assign trap_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_csr_trap_controller
// Brief   : Directed bench for csr_trap_controller (honours CSR_TRAP_COUNT_EN).
// Revision: 1.0
// ============================================================================
module tb_csr_trap_controller;

    localparam int CNT_W = 8;
`ifdef CSR_TRAP_COUNT_EN
    localparam logic [31:0] EXP_CNT1 = 32'd1;
    localparam logic [31:0] EXP_CNT3 = 32'd3;
`else
    localparam logic [31:0] EXP_CNT1 = 32'd0;
    localparam logic [31:0] EXP_CNT3 = 32'd0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             exc_valid;
    logic [31:0]      exc_pc;
    logic [4:0]       exc_cause;
    logic             exc_ack;
    logic             mret_valid;
    logic             mret_ack;
    logic             csr_wr_valid;
    logic [11:0]      csr_wr_addr;
    logic [31:0]      csr_wr_data;
    logic             csr_wr_ready;
    logic [31:0]      epc_in;
    logic             csr_we;
    logic [11:0]      csr_waddr;
    logic [31:0]      csr_wdata;
    logic             flush;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             busy;
    logic [CNT_W-1:0] trap_count;

    int tests = 0;
    int fails = 0;

    csr_trap_controller #(
        .TRAP_VECTOR (32'h0000_0100),
        .CAUSE_ADDR  (12'h001),
        .EPC_ADDR    (12'h002),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .exc_valid      (exc_valid),
        .exc_pc         (exc_pc),
        .exc_cause      (exc_cause),
        .exc_ack        (exc_ack),
        .mret_valid     (mret_valid),
        .mret_ack       (mret_ack),
        .csr_wr_valid   (csr_wr_valid),
        .csr_wr_addr    (csr_wr_addr),
        .csr_wr_data    (csr_wr_data),
        .csr_wr_ready   (csr_wr_ready),
        .epc_in         (epc_in),
        .csr_we         (csr_we),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .trap_count     (trap_count)
    );

    always #5 clk = ~clk;

    // Stand-in for the CSR block's EPC register, fed by the write port.
    logic [31:0] epc_model = 32'h0;
    always @(posedge clk) begin
        if (csr_we && csr_waddr == 12'h002) epc_model <= csr_wdata;
    end
    assign epc_in = epc_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_quiet(input string tag);
        chk({tag, "_we"}, {31'b0, csr_we}, 32'd0);
        chk({tag, "_flush"}, {31'b0, flush}, 32'd0);
        chk({tag, "_redir"}, {31'b0, redirect_valid}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        exc_valid    = 1'b0;
        exc_pc       = 32'h0;
        exc_cause    = 5'h0;
        mret_valid   = 1'b0;
        csr_wr_valid = 1'b0;
        csr_wr_addr  = 12'h0;
        csr_wr_data  = 32'h0;

        // Reset state
        #2;
        chk("rst_ready", {31'b0, csr_wr_ready}, 32'd0);
        chk("rst_ack", {31'b0, exc_ack}, 32'd0);
        chk("rst_cnt", {24'b0, trap_count}, 32'd0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk_idle_quiet("rst");
        tick();
        tick();
        reset = 1'b0;

        // Trap entry sequence
        exc_valid = 1'b1; exc_pc = 32'h0000_0040; exc_cause = 5'd2;
        #1;
        chk("t1_ack", {31'b0, exc_ack}, 32'd1);
        chk("t1_ready", {31'b0, csr_wr_ready}, 32'd0);
        chk("t1_we0", {31'b0, csr_we}, 32'd0);
        tick();
        exc_valid = 1'b0; #1;
        chk("t1_epc_we", {31'b0, csr_we}, 32'd1);
        chk("t1_epc_addr", {20'b0, csr_waddr}, 32'h002);
        chk("t1_epc_data", csr_wdata, 32'h40);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        tick(); #1;
        chk("t1_cause_we", {31'b0, csr_we}, 32'd1);
        chk("t1_cause_addr", {20'b0, csr_waddr}, 32'h001);
        chk("t1_cause_data", csr_wdata, 32'h2);
        tick(); #1;
        chk("t1_flush", {31'b0, flush}, 32'd1);
        chk("t1_redir", {31'b0, redirect_valid}, 32'd1);
        chk("t1_rpc", redirect_pc, 32'h100);
        chk("t1_we3", {31'b0, csr_we}, 32'd0);
        tick(); #1;
        chk_idle_quiet("t1_done");
        chk("t1_cnt", {24'b0, trap_count}, EXP_CNT1);

        // RS write through the buffer
        csr_wr_valid = 1'b1; csr_wr_addr = 12'h000; csr_wr_data = 32'hDEAD_BEEF;
        #1;
        chk("w_ready", {31'b0, csr_wr_ready}, 32'd1);
        chk("w_we0", {31'b0, csr_we}, 32'd0);
        tick();
        csr_wr_valid = 1'b0; #1;
        chk("w_we", {31'b0, csr_we}, 32'd1);
        chk("w_addr", {20'b0, csr_waddr}, 32'h000);
        chk("w_data", csr_wdata, 32'hDEAD_BEEF);
        chk("w_ready_drain", {31'b0, csr_wr_ready}, 32'd0);
        chk("w_busy", {31'b0, busy}, 32'd1);
        tick(); #1;
        chk("w_ready_after", {31'b0, csr_wr_ready}, 32'd1);
        chk_idle_quiet("w_done");

        // EPC write drains before mret is taken
        csr_wr_valid = 1'b1; csr_wr_addr = 12'h002; csr_wr_data = 32'h0000_0200;
        #1;
        chk("m_ready", {31'b0, csr_wr_ready}, 32'd1);
        tick();
        csr_wr_valid = 1'b0; mret_valid = 1'b1; #1;
        chk("m_drain_we", {31'b0, csr_we}, 32'd1);
        chk("m_drain_addr", {20'b0, csr_waddr}, 32'h002);
        chk("m_drain_data", csr_wdata, 32'h200);
        chk("m_ack_early", {31'b0, mret_ack}, 32'd0);
        tick(); #1;
        chk("m_ack", {31'b0, mret_ack}, 32'd1);
        tick();
        mret_valid = 1'b0; #1;
        chk("m_flush", {31'b0, flush}, 32'd1);
        chk("m_redir", {31'b0, redirect_valid}, 32'd1);
        chk("m_rpc", redirect_pc, 32'h200);
        tick(); #1;
        chk_idle_quiet("m_done");

        // Exception beats a full buffer; buffered write is dropped
        csr_wr_valid = 1'b1; csr_wr_addr = 12'h005; csr_wr_data = 32'h1234_5678;
        #1;
        tick();
        csr_wr_valid = 1'b0; exc_valid = 1'b1; exc_pc = 32'h0000_0080; exc_cause = 5'd7;
        #1;
        chk("b_ack", {31'b0, exc_ack}, 32'd1);
        chk("b_we0", {31'b0, csr_we}, 32'd0);
        tick();
        exc_valid = 1'b0; #1;
        chk("b_epc_addr", {20'b0, csr_waddr}, 32'h002);
        chk("b_epc_data", csr_wdata, 32'h80);
        tick(); #1;
        chk("b_cause_addr", {20'b0, csr_waddr}, 32'h001);
        chk("b_cause_data", csr_wdata, 32'h7);
        tick(); #1;
        chk("b_rpc", redirect_pc, 32'h100);
        chk("b_we3", {31'b0, csr_we}, 32'd0);
        tick(); #1;
        chk_idle_quiet("b_done");
        tick(); #1;
        chk_idle_quiet("b_nodrain");

        // mret held across a trap sequence
        exc_valid = 1'b1; exc_pc = 32'h0000_0300; exc_cause = 5'd3; mret_valid = 1'b1;
        #1;
        chk("h_exc_ack", {31'b0, exc_ack}, 32'd1);
        chk("h_mret_ack0", {31'b0, mret_ack}, 32'd0);
        tick();
        exc_valid = 1'b0; #1;
        chk("h_mret_ack1", {31'b0, mret_ack}, 32'd0);
        chk("h_epc_data", csr_wdata, 32'h300);
        tick(); #1;
        chk("h_mret_ack2", {31'b0, mret_ack}, 32'd0);
        tick(); #1;
        chk("h_mret_ack3", {31'b0, mret_ack}, 32'd0);
        chk("h_rpc_trap", redirect_pc, 32'h100);
        tick(); #1;
        chk("h_mret_ack", {31'b0, mret_ack}, 32'd1);
        chk("h_cnt", {24'b0, trap_count}, EXP_CNT3);
        tick();
        mret_valid = 1'b0; #1;
        chk("h_redir", {31'b0, redirect_valid}, 32'd1);
        chk("h_rpc", redirect_pc, 32'h300);
        tick(); #1;
        chk_idle_quiet("h_done");

        // Reset in the middle of SAVE_CAUSE
        exc_valid = 1'b1; exc_pc = 32'h0000_0440; exc_cause = 5'd4;
        #1;
        chk("r_ack", {31'b0, exc_ack}, 32'd1);
        tick();
        exc_valid = 1'b0;
        tick(); #1;
        chk("r_cause_we", {31'b0, csr_we}, 32'd1);
        chk("r_cause_addr", {20'b0, csr_waddr}, 32'h001);
        reset = 1'b1; #1;
        chk("r_ready", {31'b0, csr_wr_ready}, 32'd0);
        chk("r_wdata", csr_wdata, 32'd0);
        chk("r_cnt", {24'b0, trap_count}, 32'd0);
        chk_idle_quiet("r_mid");
        tick();
        reset = 1'b0; #1;
        chk_idle_quiet("r_after1");
        chk("r_ready_after", {31'b0, csr_wr_ready}, 32'd1);
        tick(); #1;
        chk_idle_quiet("r_after2");
        tick(); #1;
        chk_idle_quiet("r_after3");
        chk("r_cnt_after", {24'b0, trap_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
